decrypt_sequencer: RTL and testbench
====================================

Name: decrypt_sequencer

Overview:
Frame-level controller for the XOR byte decrypter datapath. On a start pulse it walks the encrypted frame buffer once and issues one read per cycle. Each returned byte is XORed with the latched key and written to the decrypted frame buffer at the same address. It handles memory read latency, abort and done signalling, and sits between the control logic and the two block RAMs feeding the VGA path.

Parameters:
ADDR_W, 15, width of read and write addresses
NUM_PIXELS, 19200, bytes per frame; addresses 0..NUM_PIXELS-1; must satisfy 1 <= NUM_PIXELS <= 2^ADDR_W
RD_LATENCY, 1, cycles from rd_addr/rd_en valid to rd_data valid; must be >= 1

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous reset, active-low
start  in  1  single-cycle request to decrypt one frame; sampled only in IDLE
abort  in  1  cancels the frame in progress; has priority over start
key_in  in  8  key, latched when start is accepted
rd_en  out  1  read strobe to the encrypted buffer
rd_addr  out  ADDR_W  read address
rd_data  in  8  encrypted byte, valid RD_LATENCY cycles after rd_en
wr_en  out  1  write strobe to the decrypted buffer
wr_addr  out  ADDR_W  write address
wr_data  out  8  decrypted byte
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when a full frame has been written

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - All outputs are 0: rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done.
  - Key register is 0.
  - Valid/address delay pipeline is cleared.
  - Reset mid-frame takes effect the same way; no further writes are issued.
- All outputs are registered.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1 and abort=0, latch key_in, set rd_addr=0 and rd_en=1, go to RUN. busy=1 from the next cycle.
  - RUN: rd_en=1 every cycle and rd_addr increments by 1. The cycle that presents rd_addr=NUM_PIXELS-1 is the last read; after it rd_en=0 and the state is DRAIN. rd_addr holds its last value.
  - DRAIN: wait until the delay pipeline is empty (the last write has been issued), then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Write timing:
  - Read issued in cycle t, so rd_data is valid in cycle t+RD_LATENCY.
  - In cycle t+RD_LATENCY+1: wr_en=1, wr_addr=address from cycle t, wr_data=rd_data^key.
  - The address and valid bit travel through a RD_LATENCY-deep shift register plus one output register.
- wr_en is 0 whenever no valid byte is present. wr_addr and wr_data hold their last values when wr_en=0.
- Frame timing: start sampled at edge E, so the done pulse is in cycle E+NUM_PIXELS+RD_LATENCY+2. Exactly NUM_PIXELS writes occur, with strictly increasing addresses and no gaps.
- start while busy or in DONE: ignored. No queueing.
- abort=1 in any state: next state is IDLE.
  - rd_en=0, wr_en=0 and busy=0 from the next cycle.
  - Pipeline is flushed and done is not pulsed.
  - start and abort high together in IDLE: the state stays IDLE.
- NUM_PIXELS=1: a single read, then DRAIN. The address counter never wraps.

Optional Feature:
Macro: DECRYPT_ROLLING_KEY_EN
- Defined: the key register rotates left by 1 bit after every write (wr_en=1). Byte i uses rotl(key_in, i mod 8). Key rotation resets to the latched key_in on each accepted start.
- Undefined: the key is constant for the whole frame and there is no rotation logic.

Test Plan:
- NUM_PIXELS=8, RD_LATENCY=1, key_in=8'hB3, memory[i]=i; pulse start → rd_addr 0..7 on consecutive cycles; wr_addr 0..7 with wr_data=i^8'hB3 (wr_data 8'hB3 at address 0, 8'hB2 at address 1); done pulses once, 11 cycles after the start edge.
- Same setup with RD_LATENCY=3 → first wr_en 4 cycles after the first rd_en; done at start edge+13; 8 writes, none dropped.
- Assert abort when rd_addr=4 → rd_en and wr_en go to 0 next cycle; busy=0; no done pulse; a subsequent start runs the full frame from address 0.
- Pulse start during RUN with key_in=8'h00 → ignored; all bytes still use 8'hB3; exactly one done pulse.
- Drive rst_n=0 for one cycle mid-DRAIN → all outputs 0 next cycle, state IDLE, no further wr_en.
- With DECRYPT_ROLLING_KEY_EN defined, key_in=8'hB3, memory all 8'h00 → wr_data sequence B3, 67, CE, 9D, 3B, 76, EC, D9.

Source files
------------

// File: rtl/decrypt_sequencer_if.sv
// Memory-side bus of the decrypt sequencer: read port to the encrypted frame
// buffer, write port to the decrypted frame buffer.
interface decrypt_sequencer_if #(
  parameter int ADDR_W = 15
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/decrypt_sequencer.sv
// Frame-level XOR decrypt sequencer: one read per cycle, write back key^data.
// Optional per-write left rotation of the key when DECRYPT_ROLLING_KEY_EN is defined.
module decrypt_sequencer #(
  parameter int ADDR_W     = 15,
  parameter int NUM_PIXELS = 19200,
  parameter int RD_LATENCY = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [7:0]          i_key_in,
  output logic                o_busy,
  output logic                o_done,
  decrypt_sequencer_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t r_state, w_state_nxt;

  logic                               r_rd_en;
  logic [ADDR_W-1:0]                  r_rd_addr;
  logic                               r_wr_en;
  logic [ADDR_W-1:0]                  r_wr_addr;
  logic [7:0]                         r_wr_data;
  logic                               r_busy;
  logic                               r_done;
  logic [7:0]                         r_key;
  logic [RD_LATENCY-1:0]              r_vld_pipe;
  logic [RD_LATENCY-1:0][ADDR_W-1:0]  r_addr_pipe;

  logic              w_accept;
  logic              w_empty;
  logic              w_wr_fire;
  logic              w_rd_en_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  assign w_accept  = (r_state == S_IDLE) && i_start && !i_abort;
  // Empty only once the final write has left the output register as well.
  assign w_empty   = !(|r_vld_pipe) && !r_wr_en && !r_rd_en;
  assign w_wr_fire = r_vld_pipe[RD_LATENCY-1] && !i_abort;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nxt = S_RUN;
        S_RUN:   if (r_rd_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_busy_nxt    = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_done_nxt    = (w_state_nxt == S_DONE);
    if (w_state_nxt == S_RUN) begin
      w_rd_en_nxt   = 1'b1;
      w_rd_addr_nxt = (r_state == S_IDLE) ? '0 : r_rd_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key       <= '0;
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_wr_en   <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_addr_pipe[RD_LATENCY-1];
        r_wr_data <= mem.rd_data ^ r_key;
      end

      if (i_abort) begin
        r_vld_pipe <= '0;
      end else begin
        r_vld_pipe[0] <= r_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
      r_addr_pipe[0] <= r_rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) r_addr_pipe[i] <= r_addr_pipe[i-1];

      if (w_accept) begin
        r_key <= i_key_in;
`ifdef DECRYPT_ROLLING_KEY_EN
      end else if (w_wr_fire) begin
        r_key <= {r_key[6:0], r_key[7]};
`endif
      end
    end
  end

  assign mem.rd_en   = r_rd_en;
  assign mem.rd_addr = r_rd_addr;
  assign mem.wr_en   = r_wr_en;
  assign mem.wr_addr = r_wr_addr;
  assign mem.wr_data = r_wr_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Bench for decrypt_sequencer: two instances (read latency 1 and 3) run against
// a latency-accurate memory model and a frame-level reference of expected writes.
module tb_decrypt_sequencer;
  localparam int AW = 15;
  localparam int N  = 8;
  localparam int LA = 1;
  localparam int LB = 3;

  typedef struct { int c; int a; int v; } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] mem [N];
  logic [7:0] pa [LA];
  logic [7:0] pb [LB];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        rd_q [2][$];
  ev_t        wr_q [2][$];
  int         dn_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decrypt_sequencer_if #(.ADDR_W(AW)) if_a ();
  decrypt_sequencer_if #(.ADDR_W(AW)) if_b ();

  decrypt_sequencer #(.ADDR_W(AW), .NUM_PIXELS(N), .RD_LATENCY(LA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_key_in(key_in), .o_busy(busy_a), .o_done(done_a), .mem(if_a)
  );

  decrypt_sequencer #(.ADDR_W(AW), .NUM_PIXELS(N), .RD_LATENCY(LB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_key_in(key_in), .o_busy(busy_b), .o_done(done_b), .mem(if_b)
  );

  // Block RAM model: data for the address presented in cycle t appears in t+L.
  always @(posedge clk) begin
    pa[0] <= mem[if_a.rd_addr[2:0]];
    for (int i = 1; i < LA; i++) pa[i] <= pa[i-1];
    pb[0] <= mem[if_b.rd_addr[2:0]];
    for (int i = 1; i < LB; i++) pb[i] <= pb[i-1];
  end
  assign if_a.rd_data = pa[LA-1];
  assign if_b.rd_data = pb[LB-1];

  always @(negedge clk) begin
    if (if_a.rd_en) rd_q[0].push_back('{cyc, int'(if_a.rd_addr), 0});
    if (if_b.rd_en) rd_q[1].push_back('{cyc, int'(if_b.rd_addr), 0});
    if (if_a.wr_en) wr_q[0].push_back('{cyc, int'(if_a.wr_addr), int'(if_a.wr_data)});
    if (if_b.wr_en) wr_q[1].push_back('{cyc, int'(if_b.wr_addr), int'(if_b.wr_data)});
    if (done_a) dn_q[0].push_back(cyc);
    if (done_b) dn_q[1].push_back(cyc);
  end

  function automatic logic [7:0] ref_byte(input int i, input logic [7:0] k);
    logic [15:0] kk;
    kk = {k, k};
`ifdef DECRYPT_ROLLING_KEY_EN
    kk = kk << (i % 8);
`endif
    return mem[i] ^ kk[15:8];
  endfunction

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      rd_q[d].delete();
      wr_q[d].delete();
      dn_q[d].delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.rd_en, if_a.rd_addr, if_a.wr_en, if_a.wr_addr, if_a.wr_data, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%02h busy=%b done=%b, want all 0",
               if_a.rd_en, if_a.rd_addr, if_a.wr_en, if_a.wr_addr, if_a.wr_data, busy_a, done_a);
    end
    checks++;
    if ({if_b.rd_en, if_b.rd_addr, if_b.wr_en, if_b.wr_addr, if_b.wr_data, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%02h busy=%b done=%b, want all 0",
               if_b.rd_en, if_b.rd_addr, if_b.wr_en, if_b.wr_addr, if_b.wr_data, busy_b, done_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // pat: 0 = mem[i]=i, 1 = all zero, 2 = random. mid: cycle offset of a stray start (0 = none).
  task automatic test_frame(input logic [7:0] key, input int pat, input int mid);
    int e, lat, wa;
    logic [7:0] wd;
    ev_t ev;
    for (int i = 0; i < N; i++)
      mem[i] = (pat == 0) ? 8'(i) : (pat == 1) ? 8'h00 : 8'($urandom_range(0, 255));
    clear_mon();
    start = 1'b1; key_in = key;
    @(negedge clk);
    start = 1'b0; key_in = 8'($urandom);
    e = cyc;
    checks++;
    if ({busy_a, busy_b} !== 2'b11) begin
      errors++;
      $display("FAIL busy_after_start: got a=%b b=%b, want 1 1", busy_a, busy_b);
    end
    for (int k = 1; k < 40; k++) begin
      start = (k == mid);
      if (k == mid) key_in = 8'h00;
      @(negedge clk);
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? LA : LB;
      checks++;
      if (dn_q[d].size() != 1 || dn_q[d][0] != e + N + lat + 2) begin
        errors++;
        $display("FAIL done_timing dut%0d: got %0d pulses (first at +%0d), want 1 at +%0d",
                 d, dn_q[d].size(), dn_q[d].size() > 0 ? dn_q[d][0] - e : -1, N + lat + 2);
      end
      checks++;
      if (rd_q[d].size() != N || wr_q[d].size() != N) begin
        errors++;
        $display("FAIL counts dut%0d: got %0d reads %0d writes, want %0d each",
                 d, rd_q[d].size(), wr_q[d].size(), N);
      end
      for (int i = 0; i < N; i++) begin
        if (i < rd_q[d].size()) begin
          ev = rd_q[d][i];
          checks++;
          if (ev.c != e + i || ev.a != i) begin
            errors++;
            $display("FAIL rd[%0d] dut%0d: got cyc +%0d addr %0d, want +%0d addr %0d",
                     i, d, ev.c - e, ev.a, i, i);
          end
        end
        if (i < wr_q[d].size()) begin
          ev = wr_q[d][i];
          checks++;
          if (ev.c != e + i + lat + 1 || ev.a != i || ev.v != int'(ref_byte(i, key))) begin
            errors++;
            $display("FAIL wr[%0d] dut%0d: got cyc +%0d addr %0d data %02h, want +%0d addr %0d data %02h",
                     i, d, ev.c - e, ev.a, ev.v, i + lat + 1, i, ref_byte(i, key));
          end
        end
      end
      wa = (d == 0) ? int'(if_a.wr_addr) : int'(if_b.wr_addr);
      wd = (d == 0) ? if_a.wr_data : if_b.wr_data;
      checks++;
      if (wa != N - 1 || wd !== ref_byte(N - 1, key) || ((d == 0) ? busy_a : busy_b) !== 1'b0) begin
        errors++;
        $display("FAIL hold dut%0d: got wr_addr %0d wr_data %02h, want %0d %02h, idle",
                 d, wa, wd, N - 1, ref_byte(N - 1, key));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) test_frame(8'($urandom), 2, 0);
  endtask

  task automatic test_start_ignored();
    test_frame(8'hB3, 0, 4);
    test_frame(8'hB3, 2, 12);
  endtask

  task automatic test_abort();
    int n;
    bit hit;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    clear_mon();
    start = 1'b1; key_in = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (if_a.rd_en && if_a.rd_addr == 4) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_wait: rd_addr never reached 4, want 4 within 20 cycles");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({if_a.rd_en, if_a.wr_en, busy_a, if_b.rd_en, if_b.wr_en, busy_b} !== 6'b0) begin
      errors++;
      $display("FAIL abort_outputs: got a rd/wr/busy=%b%b%b b=%b%b%b, want 000 000",
               if_a.rd_en, if_a.wr_en, busy_a, if_b.rd_en, if_b.wr_en, busy_b);
    end
    clear_mon();
    repeat (20) @(negedge clk);
    n = wr_q[0].size() + wr_q[1].size() + dn_q[0].size() + dn_q[1].size() + rd_q[0].size() + rd_q[1].size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d events after abort, want 0", n);
    end
    test_frame(8'hB3, 0, 0);
  endtask

  task automatic test_abort_start_idle();
    clear_mon();
    start = 1'b1; abort = 1'b1; key_in = 8'h77;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rd_q[0].size() + rd_q[1].size() != 0 || {busy_a, busy_b} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort_idle: got %0d reads busy=%b%b, want 0 reads busy=00",
               rd_q[0].size() + rd_q[1].size(), busy_a, busy_b);
    end
  endtask

  task automatic test_reset_drain();
    int n;
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
    clear_mon();
    start = 1'b1; key_in = 8'hC4;
    @(negedge clk);
    start = 1'b0;
    repeat (N) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({if_a.rd_en, if_a.rd_addr, if_a.wr_en, if_a.wr_addr, if_a.wr_data, busy_a, done_a,
         if_b.rd_en, if_b.rd_addr, if_b.wr_en, if_b.wr_addr, if_b.wr_data, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_drain: a wr_en=%b wr_addr=%0d busy=%b b wr_en=%b wr_addr=%0d busy=%b, want all 0",
               if_a.wr_en, if_a.wr_addr, busy_a, if_b.wr_en, if_b.wr_addr, busy_b);
    end
    clear_mon();
    repeat (20) @(negedge clk);
    n = wr_q[0].size() + wr_q[1].size() + dn_q[0].size() + dn_q[1].size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_drain_quiet: got %0d writes/dones after reset, want 0", n);
    end
  endtask

`ifdef DECRYPT_ROLLING_KEY_EN
  task automatic test_rolling_table();
    logic [7:0] tbl [8];
    tbl = '{8'hB3, 8'h67, 8'hCE, 8'h9D, 8'h3B, 8'h76, 8'hEC, 8'hD9};
    test_frame(8'hB3, 1, 0);
    for (int i = 0; i < N; i++) begin
      if (i < wr_q[0].size()) begin
        checks++;
        if (wr_q[0][i].v != int'(tbl[i])) begin
          errors++;
          $display("FAIL rolling[%0d]: got %02h, want %02h", i, wr_q[0][i].v, tbl[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame(8'hB3, 0, 0);
    test_random();
    test_start_ignored();
    test_abort();
    test_abort_start_idle();
    test_reset_drain();
    test_frame(8'h3C, 2, 0);
`ifdef DECRYPT_ROLLING_KEY_EN
    test_rolling_table();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
